// File: rtl/operand_loader_seq.sv
// Operand-entry sequencer: captures NUM_OPS switch operands one KEY press at a
// time, then runs a start/done handshake with a compute core and times it.
module operand_loader_seq #(
  parameter int WIDTH   = 16,
  parameter int NUM_OPS = 4,
  parameter int IDX_W   = 2,
  parameter int CNT_W   = 24
) (
  input  logic                     CLOCK_50,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         sw_data,
  input  logic                     key_next,
  input  logic                     key_restart,
  input  logic                     key_sel,
  input  logic [WIDTH-1:0]         res_g,
  input  logic [WIDTH-1:0]         res_h,
  input  logic                     done_in,
  output logic [NUM_OPS*WIDTH-1:0] operands,
  output logic                     start,
  output logic                     busy,
  output logic                     done_out,
  output logic [IDX_W-1:0]         load_idx,
  output logic [NUM_OPS-1:0]       progress,
  output logic [CNT_W-1:0]         lat_count,
  output logic [WIDTH-1:0]         disp,
  output logic [2:0]               dbg_state_o
);

  typedef enum logic [2:0] {
    ST_WAIT    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_RELEASE = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t                   state_q;
  logic [NUM_OPS*WIDTH-1:0] operands_q;
  logic [IDX_W-1:0]         load_idx_q;
  logic [NUM_OPS-1:0]       progress_q;
  logic [CNT_W-1:0]         lat_count_q;
  logic [WIDTH-1:0]         disp_q;
  logic [WIDTH-1:0]         disp_d;

  // Handshake: start is held high for every EXECUTE cycle; the core raises
  // done_in when finished and start falls on the following cycle (DONE).
  assign start       = (state_q == ST_EXECUTE);
  assign busy        = (state_q == ST_EXECUTE);
  assign done_out    = (state_q == ST_DONE);
  assign operands    = operands_q;
  assign load_idx    = load_idx_q;
  assign progress    = progress_q;
  assign lat_count   = lat_count_q;
  assign disp        = disp_q;
  assign dbg_state_o = state_q;

  assign disp_d = key_sel ? res_g : res_h;

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_WAIT;
      operands_q  <= '0;
      load_idx_q  <= '0;
      progress_q  <= '0;
      lat_count_q <= '0;
      disp_q      <= '0;
    end else begin
      disp_q <= disp_d;
      case (state_q)
        ST_WAIT: begin
          if (!key_next) state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          operands_q[int'(load_idx_q)*WIDTH +: WIDTH] <= sw_data;
          progress_q[load_idx_q]                      <= 1'b1;
          state_q                                     <= ST_RELEASE;
        end
        ST_RELEASE: begin
          // Waiting for key release makes one press capture exactly one operand.
          if (key_next) begin
            if (load_idx_q == IDX_W'(NUM_OPS-1)) begin
              load_idx_q  <= '0;
              lat_count_q <= '0;
              state_q     <= ST_EXECUTE;
            end else begin
              load_idx_q <= load_idx_q + IDX_W'(1);
              state_q    <= ST_WAIT;
            end
          end
        end
        ST_EXECUTE: begin
          if (done_in) begin
            state_q <= ST_DONE;
          end else if (lat_count_q != {CNT_W{1'b1}}) begin
            lat_count_q <= lat_count_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (!key_restart) begin
            progress_q <= '0;
            load_idx_q <= '0;
            state_q    <= ST_WAIT;
          end
        end
        default: state_q <= ST_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_loader_seq.sv
// Directed bench for operand_loader_seq: loading, key hold, latency timing,
// display mux, counter saturation (CNT_W=4 instance), restart and async reset.
module tb_operand_loader_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst2;
  logic [15:0] sw_data;
  logic        key_next;
  logic        key_restart;
  logic        key_sel;
  logic [15:0] res_g;
  logic [15:0] res_h;
  logic        done_in;
  logic        done_in2;

  logic [63:0] ops1;
  logic        start1, busy1, done1;
  logic [1:0]  idx1;
  logic [3:0]  prog1;
  logic [23:0] lat1;
  logic [15:0] disp1;
  logic [2:0]  st1;

  logic [63:0] ops2;
  logic        start2, busy2, done2;
  logic [1:0]  idx2;
  logic [3:0]  prog2;
  logic [3:0]  lat2;
  logic [15:0] disp2;
  logic [2:0]  st2;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk = ~clk;

  operand_loader_seq #(.WIDTH(16), .NUM_OPS(4), .IDX_W(2), .CNT_W(24)) dut (
    .CLOCK_50(clk), .rst(rst), .sw_data(sw_data), .key_next(key_next),
    .key_restart(key_restart), .key_sel(key_sel), .res_g(res_g), .res_h(res_h),
    .done_in(done_in), .operands(ops1), .start(start1), .busy(busy1),
    .done_out(done1), .load_idx(idx1), .progress(prog1), .lat_count(lat1),
    .disp(disp1), .dbg_state_o(st1)
  );

  operand_loader_seq #(.WIDTH(16), .NUM_OPS(4), .IDX_W(2), .CNT_W(4)) dut_sat (
    .CLOCK_50(clk), .rst(rst2), .sw_data(sw_data), .key_next(key_next),
    .key_restart(key_restart), .key_sel(key_sel), .res_g(res_g), .res_h(res_h),
    .done_in(done_in2), .operands(ops2), .start(start2), .busy(busy2),
    .done_out(done2), .load_idx(idx2), .progress(prog2), .lat_count(lat2),
    .disp(disp2), .dbg_state_o(st2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [15:0] v);
    sw_data  = v;
    key_next = 1'b0;
    tick();
    tick();
    key_next = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; rst2 = 1'b0;
    sw_data = 16'h0; key_next = 1'b1; key_restart = 1'b1; key_sel = 1'b0;
    res_g = 16'h0; res_h = 16'h0; done_in = 1'b0; done_in2 = 1'b0;
    tick(); tick();
    n_tests++;
    if ({st1, start1, busy1, done1} !== 6'b000_000) begin
      n_fail++; $display("FAIL reset_ctrl got st=%0d s/b/d=%b%b%b want 0 000", st1, start1, busy1, done1);
    end
    n_tests++;
    if ({ops1, idx1, prog1, lat1, disp1} !== '0) begin
      n_fail++; $display("FAIL reset_regs got ops=%h idx=%0d prog=%b lat=%0d disp=%h want all 0", ops1, idx1, prog1, lat1, disp1);
    end
    #5 rst = 1'b1;
    tick();
    n_tests++;
    if (st1 !== 3'd0) begin
      n_fail++; $display("FAIL reset_idle got st=%0d want 0", st1);
    end
  endtask

  task automatic test_load();
    logic [15:0] vals [4];
    logic [3:0]  exp_prog [4];
    vals = '{16'h0001, 16'h0002, 16'h00FF, 16'hBEEF};
    exp_prog = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    for (int i = 0; i < 4; i++) begin
      press(vals[i]);
      n_tests++;
      if (prog1 !== exp_prog[i]) begin
        n_fail++; $display("FAIL load_progress%0d got %b want %b", i, prog1, exp_prog[i]);
      end
    end
    n_tests++;
    if (ops1 !== 64'hBEEF_00FF_0002_0001) begin
      n_fail++; $display("FAIL load_operands got %h want beef00ff00020001", ops1);
    end
    n_tests++;
    if ({start1, busy1, idx1, lat1} !== {1'b1, 1'b1, 2'd0, 24'd0}) begin
      n_fail++; $display("FAIL load_start got start=%b busy=%b idx=%0d lat=%0d want 1 1 0 0", start1, busy1, idx1, lat1);
    end
  endtask

  task automatic test_execute();
    repeat (5) tick();
    n_tests++;
    if ({st1, start1, lat1} !== {3'd3, 1'b1, 24'd5}) begin
      n_fail++; $display("FAIL exec_running got st=%0d start=%b lat=%0d want 3 1 5", st1, start1, lat1);
    end
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    n_tests++;
    if ({done1, start1, busy1, lat1} !== {1'b1, 1'b0, 1'b0, 24'd5}) begin
      n_fail++; $display("FAIL exec_done got done=%b start=%b busy=%b lat=%0d want 1 0 0 5", done1, start1, busy1, lat1);
    end
    tick(); tick();
    n_tests++;
    if ({done1, lat1} !== {1'b1, 24'd5}) begin
      n_fail++; $display("FAIL exec_frozen got done=%b lat=%0d want 1 5", done1, lat1);
    end
  endtask

  task automatic test_disp();
    key_sel = 1'b1; res_g = 16'h1234; res_h = 16'h5555;
    tick();
    n_tests++;
    if (disp1 !== 16'h1234) begin
      n_fail++; $display("FAIL disp_g got %h want 1234", disp1);
    end
    key_sel = 1'b0; res_h = 16'hABCD;
    tick();
    n_tests++;
    if (disp1 !== 16'hABCD) begin
      n_fail++; $display("FAIL disp_h got %h want abcd", disp1);
    end
  endtask

  task automatic test_saturate();
    #5 rst2 = 1'b1;
    for (int i = 0; i < 4; i++) press(16'h0010 + 16'(i));
    n_tests++;
    if ({st2, start2, lat2} !== {3'd3, 1'b1, 4'd0}) begin
      n_fail++; $display("FAIL sat_enter got st=%0d start=%b lat=%0d want 3 1 0", st2, start2, lat2);
    end
    n_tests++;
    if ({done1, st1} !== {1'b1, 3'd4}) begin
      n_fail++; $display("FAIL done_ignores_next got done=%b st=%0d want 1 4", done1, st1);
    end
    repeat (40) tick();
    n_tests++;
    if ({lat2, start2} !== {4'hF, 1'b1}) begin
      n_fail++; $display("FAIL sat_hold got lat=%h start=%b want f 1", lat2, start2);
    end
    done_in2 = 1'b1;
    tick();
    done_in2 = 1'b0;
    n_tests++;
    if ({done2, start2, lat2} !== {1'b1, 1'b0, 4'hF}) begin
      n_fail++; $display("FAIL sat_done got done=%b start=%b lat=%h want 1 0 f", done2, start2, lat2);
    end
  endtask

  task automatic test_restart();
    key_restart = 1'b0; key_next = 1'b0;
    tick();
    key_restart = 1'b1; key_next = 1'b1;
    n_tests++;
    if ({st1, done1, prog1, idx1} !== {3'd0, 1'b0, 4'd0, 2'd0}) begin
      n_fail++; $display("FAIL restart_state got st=%0d done=%b prog=%b idx=%0d want 0 0 0000 0", st1, done1, prog1, idx1);
    end
    n_tests++;
    if ({ops1, lat1} !== {64'hBEEF_00FF_0002_0001, 24'd5}) begin
      n_fail++; $display("FAIL restart_keep got ops=%h lat=%0d want beef00ff00020001 5", ops1, lat1);
    end
    #5 rst2 = 1'b0;
    press(16'h5A5A);
    n_tests++;
    if ({ops1, prog1, idx1} !== {64'hBEEF_00FF_0002_5A5A, 4'b0001, 2'd1}) begin
      n_fail++; $display("FAIL reload_op0 got ops=%h prog=%b idx=%0d want beef00ff00025a5a 0001 1", ops1, prog1, idx1);
    end
  endtask

  task automatic test_hold();
    sw_data = 16'h1111; key_next = 1'b0;
    tick(); tick();
    sw_data = 16'h2222;
    repeat (48) tick();
    n_tests++;
    if ({st1, idx1} !== {3'd2, 2'd1}) begin
      n_fail++; $display("FAIL hold_wait got st=%0d idx=%0d want 2 1", st1, idx1);
    end
    key_next = 1'b1;
    tick();
    n_tests++;
    if ({st1, idx1, ops1[31:16], prog1} !== {3'd0, 2'd2, 16'h1111, 4'b0011}) begin
      n_fail++; $display("FAIL hold_release got st=%0d idx=%0d op1=%h prog=%b want 0 2 1111 0011", st1, idx1, ops1[31:16], prog1);
    end
  endtask

  task automatic test_reset_mid();
    sw_data = 16'h3333; key_next = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_tests++;
    if ({st1, start1, busy1, ops1, prog1, lat1, idx1} !== '0) begin
      n_fail++; $display("FAIL rst_release_mid got st=%0d start=%b ops=%h prog=%b lat=%0d idx=%0d want all 0", st1, start1, ops1, prog1, lat1, idx1);
    end
    key_next = 1'b1;
    #5 rst = 1'b1;
    tick();
    n_tests++;
    if ({st1, start1} !== {3'd0, 1'b0}) begin
      n_fail++; $display("FAIL rst_release_after got st=%0d start=%b want 0 0", st1, start1);
    end
    for (int i = 0; i < 4; i++) press(16'hC000 + 16'(i));
    tick(); tick();
    n_tests++;
    if ({busy1, start1, lat1} !== {1'b1, 1'b1, 24'd2}) begin
      n_fail++; $display("FAIL rst_exec_pre got busy=%b start=%b lat=%0d want 1 1 2", busy1, start1, lat1);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if ({st1, start1, busy1, ops1, prog1, lat1} !== '0) begin
      n_fail++; $display("FAIL rst_exec_mid got st=%0d start=%b busy=%b ops=%h prog=%b lat=%0d want all 0", st1, start1, busy1, ops1, prog1, lat1);
    end
    #5 rst = 1'b1;
    tick();
    n_tests++;
    if ({st1, start1, busy1} !== {3'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL rst_exec_after got st=%0d start=%b busy=%b want 0 0 0", st1, start1, busy1);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_execute();
    test_disp();
    test_saturate();
    test_restart();
    test_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
